// File: rtl/dmem_store_buffer_if.sv
// Memory-side bus of the data-memory store buffer: drain write handshake plus load bypass.
// master = store buffer, slave = data memory.
interface dmem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_raddr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_raddr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer: core stores retire into a FIFO and a drain FSM writes them to memory in order.
// Optional DMEM_STORE_FWD_EN: loads are forwarded from the youngest matching pending store.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  dmem_store_buffer_if.master    mem
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = AW - 2;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, next_state;

  logic [TW-1:0] tag_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
  logic          full, enq, pop, load, next_req;
  logic [TW-1:0] load_tag;
  logic [DW-1:0] load_data;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign enq           = cpu_we & ~full;
  assign cpu_stall     = cpu_we & full;
  assign pop           = (state == BUSY) & mem.mem_ack;
  assign rd_next       = rd_ptr + PW'(1);
  assign mem.mem_raddr = cpu_addr;

  // Drain control. On an ack with nothing left queued, a store arriving in the same
  // cycle is taken straight from the core inputs so the request never bubbles.
  always_comb begin
    next_state = state;
    next_req   = mem.mem_req;
    load       = 1'b0;
    load_tag   = tag_q[rd_ptr];
    load_data  = data_q[rd_ptr];
    case (state)
      IDLE: begin
        if (!empty) begin
          load       = 1'b1;
          next_req   = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          if (count > CW'(1)) begin
            load      = 1'b1;
            load_tag  = tag_q[rd_next];
            load_data = data_q[rd_next];
          end else if (enq) begin
            load      = 1'b1;
            load_tag  = cpu_addr[AW-1:2];
            load_data = cpu_wdata;
          end else begin
            next_req   = 1'b0;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else begin
      state       <= next_state;
      mem.mem_req <= next_req;
      if (load) begin
        mem.mem_addr  <= {load_tag, 2'b00};
        mem.mem_wdata <= load_data;
      end
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_next;
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: validity is implied by rd_ptr and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      tag_q[wr_ptr]  <= cpu_addr[AW-1:2];
      data_q[wr_ptr] <= cpu_wdata;
    end
  end

`ifdef DMEM_STORE_FWD_EN
  // Scan oldest to youngest so the youngest matching entry (in-flight one included) wins.
  always_comb begin
    cpu_rdata = mem.mem_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (tag_q[rd_ptr + PW'(k)] == cpu_addr[AW-1:2]))
        cpu_rdata = data_q[rd_ptr + PW'(k)];
    end
  end
`else
  assign cpu_rdata = mem.mem_rdata;
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
  a_no_empty_pop: assert property (@(posedge clk) disable iff (reset) pop |-> (count != '0));
  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (mem.mem_req && !mem.mem_ack) |=>
      (mem.mem_req && $stable(mem.mem_addr) && $stable(mem.mem_wdata)));
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized bench for dmem_store_buffer against a queue-based reference model.
// Honours DMEM_STORE_FWD_EN for the expected load data.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [2:0]  count;
  logic        empty;

  dmem_store_buffer_if #(.AW(32), .DW(32)) ifc ();

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .count     (count),
    .empty     (empty),
    .mem       (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending stores in program order, head is the one being drained.
  logic [31:0] padr [$];
  logic [31:0] pdat [$];
  bit          busy = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  int          n_acc = 0;
  int          n_wr = 0;
  int          n_drop = 0;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, check combinational outputs, then
  // advance the model across the rising edge and check registered outputs.
  task automatic applyStimulus(input bit we, input logic [31:0] a, input logic [31:0] d,
                               input bit ack);
    logic [31:0] rd, exp_rd, seen_addr, seen_data;
    logic        seen_req;
    int          pre;
    @(negedge clk);
    rd            = $urandom;
    cpu_we        = we;
    cpu_addr      = a;
    cpu_wdata     = d;
    ifc.mem_ack   = ack;
    ifc.mem_rdata = rd;
    #1;
    checkOutput("stall", 64'(cpu_stall), 64'(we && (padr.size() == DEPTH)));
    checkOutput("raddr", 64'(ifc.mem_raddr), 64'(a));
    if (!we) begin
      exp_rd = rd;
`ifdef DMEM_STORE_FWD_EN
      foreach (padr[i]) if (padr[i][31:2] == a[31:2]) exp_rd = pdat[i];
`endif
      checkOutput("rdata", 64'(cpu_rdata), 64'(exp_rd));
    end
    seen_req  = ifc.mem_req;
    seen_addr = ifc.mem_addr;
    seen_data = ifc.mem_wdata;
    @(posedge clk);
    pre = padr.size();
    if (we && pre < DEPTH) begin
      padr.push_back(a & 32'hFFFF_FFFC);
      pdat.push_back(d);
      n_acc++;
    end
    if (busy && ack) begin
      checkOutput("wr_req", 64'(seen_req), 64'(1));
      checkOutput("wr_addr", 64'(seen_addr), 64'(padr[0]));
      checkOutput("wr_data", 64'(seen_data), 64'(pdat[0]));
      void'(padr.pop_front());
      void'(pdat.pop_front());
      n_wr++;
      busy = (padr.size() > 0);
    end else if (!busy) begin
      busy = (pre > 0);
    end
    if (busy) begin
      exp_addr = padr[0];
      exp_data = pdat[0];
    end
    #1;
    checkOutput("count", 64'(count), 64'(padr.size()));
    checkOutput("empty", 64'(empty), 64'(padr.size() == 0));
    checkOutput("mem_req", 64'(ifc.mem_req), 64'(busy));
    checkOutput("mem_addr", 64'(ifc.mem_addr), 64'(exp_addr));
    checkOutput("mem_wdata", 64'(ifc.mem_wdata), 64'(exp_data));
  endtask

  task automatic doReset();
    @(negedge clk);
    cpu_we      = 1'b0;
    ifc.mem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_req", 64'(ifc.mem_req), 64'(0));
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_empty", 64'(empty), 64'(1));
    checkOutput("rst_addr", 64'(ifc.mem_addr), 64'(0));
    n_drop  += padr.size();
    padr.delete();
    pdat.delete();
    busy     = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ifc.mem_ack   = 1'b0;
    ifc.mem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("init_count", 64'(count), 64'(0));
    checkOutput("init_empty", 64'(empty), 64'(1));
    checkOutput("init_req", 64'(ifc.mem_req), 64'(0));
    checkOutput("init_wdata", 64'(ifc.mem_wdata), 64'(0));
    reset = 1'b0;

    $display("[TB] single store");
    applyStimulus(1'b1, 32'h64, 32'd7, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'd0, 1'b0);

    $display("[TB] fill and stall");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h60 + 32'(4 * i), 32'(i + 1), 1'b0);
    applyStimulus(1'b1, 32'h70, 32'd5, 1'b1);
    applyStimulus(1'b1, 32'h70, 32'd5, 1'b1);
    repeat (6) applyStimulus(1'b0, 32'h0, 32'd0, 1'b1);

    $display("[TB] back-to-back drain");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h80 + 32'(4 * i), 32'(i + 16), 1'b0);
    applyStimulus(1'b0, 32'h0, 32'd0, 1'b0);
    repeat (5) applyStimulus(1'b0, 32'h0, 32'd0, 1'b1);

    $display("[TB] enqueue with pop and wrap");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h90 + 32'(4 * i), 32'(i + 32), 1'b0);
    applyStimulus(1'b0, 32'h0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h98, 32'd34, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'hA0 + 32'(4 * i), 32'(i + 48), i[0]);
    repeat (8) applyStimulus(1'b0, 32'h0, 32'd0, 1'b1);

    $display("[TB] reset while busy");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC0 + 32'(4 * i), 32'(i + 64), 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 32'd0, 1'b0);
    doReset();
    repeat (4) applyStimulus(1'b0, 32'h0, 32'd0, 1'b1);

    $display("[TB] load after store");
    applyStimulus(1'b1, 32'h60, 32'd3, 1'b0);
    applyStimulus(1'b1, 32'h60, 32'd9, 1'b0);
    applyStimulus(1'b0, 32'h62, 32'd0, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h62, 32'd0, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 9) < 6),
                    32'h60 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                    $urandom, ($urandom_range(0, 2) != 0));
    end
    repeat (DEPTH + 4) applyStimulus(1'b0, 32'h0, 32'd0, 1'b1);
    checkOutput("all_written", 64'(n_wr), 64'(n_acc - n_drop));
    checkOutput("final_empty", 64'(empty), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
